pe_grant_decoder: RTL and testbench
===================================

Name: pe_grant_decoder

Overview:
- Inverse of the team's priority encoder: accepts an encoded winner index plus a "none active" flag and expands it into a registered one-hot grant vector.
- Enforces a minimum grant hold time, a downstream valid/ready release handshake, and one dead cycle between grants.
- Sits between the priority encoder output and the requesting agents.

Parameters:
- N, 3, number of grant lines (must be >= 2).
- IDX_W, $clog2(N), width of the encoded index.
- HOLD_CYC, 4, minimum cycles gnt stays asserted (must be >= 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  encoded input valid.
- in_ready  out  1  block can accept an input.
- in_code  in  IDX_W  winner index from the encoder.
- in_none  in  1  encoder reports no request active.
- gnt_valid  out  1  grant vector valid.
- gnt_ready  in  1  consumer releases the grant.
- gnt  out  N  one-hot grant, registered.
- busy  out  1  FSM is not IDLE.
- err  out  1  out-of-range index pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_valid=0, hold_cnt=0, err=0, busy=0. in_ready is combinational, so it reads 1 in IDLE.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - in_ready=1. An input is accepted when in_valid=1.
  - in_none=1: input consumed, no grant issued, stay IDLE.
  - Otherwise: gnt <= 1<<in_code, gnt_valid <= 1, hold_cnt <= HOLD_CYC-1, go to GRANT.
- GRANT:
  - in_ready=0. hold_cnt decrements each cycle while nonzero.
  - Release occurs when gnt_valid && gnt_ready && hold_cnt==0. On release: gnt <= 0, gnt_valid <= 0, go to RELEASE.
  - gnt_ready asserted while hold_cnt != 0 is ignored.
  - gnt must stay stable and one-hot throughout GRANT.
- RELEASE: in_ready=0, exactly one cycle, then go to IDLE.
- Latency:
  - Input accepted at edge k; gnt visible after edge k.
  - With gnt_ready tied high, the grant is held exactly HOLD_CYC cycles.
  - Minimum spacing between accepted inputs is HOLD_CYC+2 cycles.
- busy = (state != IDLE).
- Index rule: in_code >= N with in_none=0 counts as out-of-range (see optional feature).
- Reset mid-GRANT: gnt clears immediately (async); no release handshake occurs.
- in_valid while in_ready=0: ignored. The source must hold its input.

Optional Feature:
- Macro: PE_RANGE_CHK_EN.
- Defined:
  - An out-of-range in_code is consumed in IDLE; err pulses high for exactly one cycle (registered); no grant; stay IDLE.
- Undefined:
  - An out-of-range code enters GRANT with gnt=0 (shift result masked to N bits).
  - gnt_valid=1 and the normal hold/release sequence runs.
  - err is tied 0.

Decomposition:
- Shared package pe_pkg holds:
  - FSM state typedef (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - PE_N_DEFAULT=3;
  - PE_HOLD_DEFAULT=4.
  - The encoder and its testbench use the same package.
- One natural sub-module, pe_hold_timer: loadable down-counter with a zero flag, parameter HOLD_CYC.
- The one-hot expansion stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT with gnt=3'b010 -> gnt=0, gnt_valid=0, busy=0 asynchronously; in_ready=1 after release.
- Basic decode, gnt_ready=1: sweep in_code=0,1,2 with in_none=0 -> gnt=001, 010, 100. Each held exactly 4 cycles, one dead cycle, next accept 6 cycles after the previous.
- None flag: in_valid=1, in_none=1, in_code=2 -> in_ready stays 1, gnt stays 0, busy stays 0.
- Backpressure: gnt_ready=0 for 10 cycles after grant 3'b100 -> gnt held 10+ cycles. in_valid pulses meanwhile are not accepted. Raise gnt_ready -> release next edge, RELEASE one cycle.
- Early ready: gnt_ready=1 from the first GRANT cycle, HOLD_CYC=4 -> gnt still held 4 cycles, never shorter.
- Out-of-range: in_code=3, N=3:
  - with PE_RANGE_CHK_EN -> err one-cycle pulse, no grant, stays IDLE;
  - without -> gnt=0, gnt_valid=1 for 4 cycles, err=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the priority encoder / grant decoder pair.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } pe_state_t;

    localparam int PE_N_DEFAULT    = 3;
    localparam int PE_HOLD_DEFAULT = 4;

endpackage

// File: rtl/pe_hold_timer.sv
// Loadable down-counter that saturates at zero; zero flags the end of the minimum hold.
module pe_hold_timer #(
    parameter int HOLD_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(HOLD_CYC - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pe_grant_decoder.sv
// Expands an encoded winner index into a registered one-hot grant with minimum hold,
// valid/ready release and one dead cycle. Optional range check: PE_RANGE_CHK_EN.
module pe_grant_decoder
    import pe_pkg::*;
#(
    parameter int N        = PE_N_DEFAULT,
    parameter int IDX_W    = $clog2(N),
    parameter int HOLD_CYC = PE_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_code,
    input  logic             in_none,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             err
);

    pe_state_t  state;
    pe_state_t  state_next;
    logic       accept;
    logic       start_grant;
    logic       release_grant;
    logic       hold_zero;
    logic [N-1:0] one_hot;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // Shifting an N-bit one by an index >= N leaves zero, which is the masked result.
    assign one_hot = {{(N-1){1'b0}}, 1'b1} << in_code;

`ifdef PE_RANGE_CHK_EN
    logic code_oor;
    assign code_oor    = (int'(in_code) >= N);
    assign start_grant = accept && !in_none && !code_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= accept && !in_none && code_oor;
        end
    end
`else
    assign start_grant = accept && !in_none;
    assign err         = 1'b0;
`endif

    assign release_grant = (state == GRANT) && gnt_valid && gnt_ready && hold_zero;

    pe_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_grant),
        .dec   (state == GRANT),
        .zero  (hold_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_grant) state_next = GRANT;
            GRANT:   if (release_grant) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else if (start_grant) begin
            gnt       <= one_hot;
            gnt_valid <= 1'b1;
        end else if (release_grant) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_grant_decoder.sv
// Self-checking bench for pe_grant_decoder: directed cases plus randomized traffic
// checked every cycle against a cycle-counting behavioural model.
module tb_pe_grant_decoder;
    import pe_pkg::*;

    localparam int N     = 3;
    localparam int IDX_W = 2;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_none = 1'b0;
    logic             gnt_ready = 1'b0;
    logic [IDX_W-1:0] in_code = '0;
    logic             in_ready;
    logic             gnt_valid;
    logic             busy;
    logic             err;
    logic [N-1:0]     gnt;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    bit           m_active = 0;
    bit           m_dead = 0;
    bit           m_err = 0;
    int           m_age = 0;
    int           m_idx = 0;
    logic [N-1:0] m_gnt = '0;

    int accept_q[$];
    int run_q[$];
    int run_len = 0;

    logic [N-1:0] exp_tab [3] = '{3'b001, 3'b010, 3'b100};

    pe_grant_decoder #(
        .N        (N),
        .IDX_W    (IDX_W),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_none   (in_none),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .gnt       (gnt),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic none, input logic [IDX_W-1:0] code,
                                 input logic rdy);
        in_valid  = v;
        in_none   = none;
        in_code   = code;
        gnt_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns just after the edge that accepted the pending input.
    task automatic waitAccept(input string name);
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: no accept within 40 cycles", name);
    endtask

    // Model: a grant is visible for at least HOLD cycles, ends on the first edge after
    // that with ready high, and is followed by one dead cycle.
    task automatic modelStep();
        m_err = 0;
        if (m_dead) begin
            m_dead = 0;
        end else if (m_active) begin
            m_age++;
            if (m_age >= HOLD && gnt_ready) begin
                m_active = 0;
                m_dead   = 1;
                m_gnt    = '0;
            end
        end else if (in_valid && !in_none) begin
            m_idx = int'(in_code);
            if (m_idx >= N) begin
`ifdef PE_RANGE_CHK_EN
                m_err = 1;
`else
                m_active = 1;
                m_age    = 0;
                m_gnt    = '0;
`endif
            end else begin
                m_active     = 1;
                m_age        = 0;
                m_gnt        = '0;
                m_gnt[m_idx] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            m_active = 0;
            m_dead   = 0;
            m_err    = 0;
            m_age    = 0;
            m_gnt    = '0;
        end
        checkOutput("model_gnt", gnt, m_gnt);
        checkOutput("model_gnt_valid", gnt_valid, m_active);
        checkOutput("model_busy", busy, m_active || m_dead);
        checkOutput("model_in_ready", in_ready, !(m_active || m_dead));
        checkOutput("model_err", err, m_err);
        checkOutput("onehot", ($countones(gnt) <= 1), 1);
        if (rst_n && in_valid && in_ready) accept_q.push_back(cycle);
        if (gnt_valid) begin
            run_len++;
        end else if (run_len != 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
        if (rst_n) modelStep();
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checkOutput("reset_gnt", gnt, 3'b000);
        checkOutput("reset_gnt_valid", gnt_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_err", err, 0);

        // Back-to-back sweep with ready held high.
        accept_q.delete();
        run_q.delete();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 0, IDX_W'(c), 1);
            waitAccept("sweep_accept");
            checkOutput("sweep_gnt", gnt, exp_tab[c]);
        end
        applyStimulus(0, 0, 0, 1);
        repeat (8) tick();
        checkOutput("sweep_accept_count", accept_q.size(), 3);
        for (int i = 1; i < accept_q.size(); i++)
            checkOutput("sweep_spacing", accept_q[i] - accept_q[i-1], 6);
        checkOutput("sweep_run_count", run_q.size(), 3);
        foreach (run_q[i]) checkOutput("sweep_hold_len", run_q[i], 4);

        // None flag consumes the input without granting.
        applyStimulus(1, 1, 2, 1);
        repeat (3) begin
            tick();
            checkOutput("none_in_ready", in_ready, 1);
            checkOutput("none_gnt", gnt, 3'b000);
            checkOutput("none_busy", busy, 0);
        end

        // Backpressure: ready low for 10 cycles, stray valid pulses ignored.
        run_q.delete();
        applyStimulus(1, 0, 2, 0);
        waitAccept("bp_accept");
        accept_q.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(logic'(i % 2), 0, 0, 0);
            tick();
            checkOutput("bp_gnt_held", gnt, 3'b100);
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("bp_no_accept", accept_q.size(), 0);
        tick();
        checkOutput("bp_release_gnt", gnt, 3'b000);
        checkOutput("bp_release_valid", gnt_valid, 0);
        checkOutput("bp_release_busy", busy, 1);
        checkOutput("bp_release_in_ready", in_ready, 0);
        tick();
        checkOutput("bp_idle_busy", busy, 0);
        checkOutput("bp_idle_in_ready", in_ready, 1);
        checkOutput("bp_run_len", (run_q.size() > 0) ? run_q[0] : -1, 11);

        // Out-of-range index.
        run_q.delete();
        applyStimulus(1, 0, 3, 1);
        waitAccept("oor_accept");
`ifdef PE_RANGE_CHK_EN
        checkOutput("oor_err_pulse", err, 1);
        checkOutput("oor_busy", busy, 0);
        checkOutput("oor_gnt", gnt, 3'b000);
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("oor_err_clear", err, 0);
`else
        checkOutput("oor_gnt", gnt, 3'b000);
        checkOutput("oor_gnt_valid", gnt_valid, 1);
        checkOutput("oor_err", err, 0);
        applyStimulus(0, 0, 0, 1);
        repeat (7) tick();
        checkOutput("oor_hold_len", (run_q.size() > 0) ? run_q[0] : -1, 4);
`endif

        // Asynchronous reset in the middle of a grant.
        applyStimulus(1, 0, 1, 0);
        waitAccept("rst_accept");
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("rst_pre_gnt", gnt, 3'b010);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_gnt", gnt, 3'b000);
        checkOutput("rst_async_gnt_valid", gnt_valid, 0);
        checkOutput("rst_async_busy", busy, 0);
        checkOutput("rst_async_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          IDX_W'($urandom_range(0, 3)),
                          logic'($urandom_range(0, 1)));
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
